hash_core_arbiter: RTL

- Shares one hash core between up to NREQ requesters in the signing flow (commitment, Ch hash, Cv hash, seed tree expansion).
- Each requester presents one message block and a level request. The arbiter grants requesters round-robin and launches the core with a one-cycle start.
- It returns the digest with a sticky per-requester done flag, following the codebase start/end convention: done is held until the requester drops its request.
- A watchdog aborts a hung core operation.

---
 rtl/hash_core_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hash_core_arbiter.sv
// hash_core_arbiter
//   Shares a single hash core between NREQ requesters (commitment, Ch hash,
//   Cv hash, seed tree expansion). Requesters are granted round-robin. Each
//   grant registers the requester's message block and pulses core_start for
//   one cycle. The core's digest is returned with a sticky per-requester
//   done flag, which is held until that requester drops its request. A
//   watchdog aborts a core operation that stays BUSY for TIMEOUT cycles.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   req          level request per requester, held until done[i] is seen
//   msg_in       message blocks, requester i at [i*DW +: DW]
//   core_start   one-cycle launch pulse to the hash core
//   core_msg     registered message block driven to the core
//   core_digest  core result, valid while core_done is high
//   core_done    core completion pulse
//   grant        one-hot, identifies the requester being served
//   done         sticky per-requester completion flags
//   digest       most recently captured digest
//   busy         high while an operation is in LAUNCH or BUSY
//   error        one-cycle pulse on watchdog abort
//   err_id       index of the aborted requester
module hash_core_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 256,
    parameter int HW      = 256,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   msg_in,
    output logic                 core_start,
    output logic [DW-1:0]        core_msg,
    input  logic [HW-1:0]        core_digest,
    input  logic                 core_done,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [HW-1:0]        digest,
    output logic                 busy,
    output logic                 error,
    output logic [2:0]           err_id
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

    state_t          state_reg;
    logic [IW-1:0]   ptr_reg;
    logic [IW-1:0]   idx_reg;
    logic [CW-1:0]   cnt_reg;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] done_clr;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   ptr_next;
    logic [NREQ-1:0] pick_onehot;
    logic [DW-1:0]   pick_msg;
    logic [IW-1:0]   cand_idx [NREQ];

    // A requester whose done flag is still up cannot be regranted; the flag
    // only drops once the request has been sampled low.
    assign eligible = req & ~done;
    assign done_clr = done & req;

    // cand_idx[gi] is the requester gi positions after the pointer, modulo NREQ.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IW:0] sum;
            assign sum          = {1'b0, ptr_reg} + (IW+1)'(gi);
            assign cand_idx[gi] = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ))
                                                         : sum[IW-1:0];
        end
    endgenerate

    // Scan from the farthest offset down so the candidate closest to the
    // pointer is the one left standing.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (eligible[cand_idx[k]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    assign pick_onehot = NREQ'(1) << pick_idx;
    assign pick_msg    = msg_in[int'(pick_idx) * DW +: DW];
    assign ptr_next    = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            core_start <= 1'b0;
            core_msg   <= '0;
            grant      <= '0;
            done       <= '0;
            digest     <= '0;
            busy       <= 1'b0;
            error      <= 1'b0;
            err_id     <= '0;
        end else begin
            core_start <= 1'b0;
            error      <= 1'b0;
            done       <= done_clr;
            case (state_reg)
                IDLE: begin
                    // core_done here is a stray pulse and is ignored.
                    if (pick_valid) begin
                        grant      <= pick_onehot;
                        idx_reg    <= pick_idx;
                        core_msg   <= pick_msg;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        ptr_reg    <= ptr_next;
                        state_reg  <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // A core_done coinciding with the launch cycle cannot
                    // belong to this operation.
                    cnt_reg   <= '0;
                    state_reg <= BUSY;
                end
                BUSY: begin
                    if (core_done) begin
                        // A withdrawn requester gets nothing: result dropped.
                        if (req[idx_reg]) begin
                            digest <= core_digest;
                            done   <= done_clr | grant;
                        end
                        grant     <= '0;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                        // Abort: release the requester with done set so it
                        // is not left waiting, digest left as it was.
                        error     <= 1'b1;
                        err_id    <= 3'(idx_reg);
                        done      <= done_clr | grant;
                        grant     <= '0;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
